// File: rtl/axi4_lite_master_read.sv
// Single-beat AXI4-Lite read master: one request in IDLE issues AR then waits for R,
// with a data-phase timeout. All outputs except AR_PROT come straight from flops.
module axi4_lite_master_read #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start_read,
    input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
    output logic [AXI_DATA_WIDTH-1:0] o_data,
    output logic                      o_done,
    output logic                      o_error,
    output logic                      o_timeout,
    output logic                      o_busy,
    output logic                      AR_VALID,
    output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
    output logic [2:0]                AR_PROT,
    input  logic                      AR_READY,
    output logic                      R_READY,
    input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
    input  logic [1:0]                R_RESP,
    input  logic                      R_VALID
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    // Every registered output plus the timeout counter, updated as one unit.
    typedef struct packed {
        logic                      ar_valid;
        logic [AXI_ADDR_WIDTH-1:0] ar_addr;
        logic                      r_ready;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic                      done;
        logic                      error;
        logic                      timeout;
        logic                      busy;
        logic [CNT_W-1:0]          cnt;
    } regs_t;

    state_t state, state_nxt;
    regs_t  q, d;
    logic   ar_hs, r_hs, cnt_last;

    assign ar_hs    = q.ar_valid & AR_READY;
    assign r_hs     = q.r_ready & R_VALID;
    assign cnt_last = (q.cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
        end else begin
            state <= state_nxt;
            q     <= d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start_read) state_nxt = ADDR;
            ADDR:    if (ar_hs) state_nxt = DATA;
            DATA:    if (r_hs || cnt_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the output flops; R handshake takes priority over terminal count.
    always_comb begin
        d      = q;
        d.done = 1'b0;
        d.busy = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (i_start_read) begin
                    d.ar_addr  = i_addr;
                    d.ar_valid = 1'b1;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    d.ar_valid = 1'b0;
                    d.r_ready  = 1'b1;
                    d.cnt      = '0;
                end
            end
            DATA: begin
                if (r_hs) begin
                    d.data    = R_DATA;
                    d.error   = (R_RESP != 2'b00);
                    d.timeout = 1'b0;
                    d.r_ready = 1'b0;
                    d.done    = 1'b1;
                end else if (cnt_last) begin
                    d.error   = 1'b1;
                    d.timeout = 1'b1;
                    d.r_ready = 1'b0;
                    d.done    = 1'b1;
                end else begin
                    d.cnt = q.cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_data    = q.data;
    assign o_done    = q.done;
    assign o_error   = q.error;
    assign o_timeout = q.timeout;
    assign o_busy    = q.busy;
    assign AR_VALID  = q.ar_valid;
    assign AR_ADDR   = q.ar_addr;
    assign R_READY   = q.r_ready;
    assign AR_PROT   = 3'b000;
endmodule
